// File: rtl/sec_lock_pipe.sv
// Key-locked, two-stage valid/ready SEC Hamming decoder with a serially loaded key.
// Stage 1 registers the key-gated syndrome, stage 2 corrects, extracts and masks the data.
module sec_lock_pipe #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 6,
  localparam int N     = DATA_W + CHK_W,
  localparam int KEY_W = N + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_we,
  input  logic              key_in,
  input  logic              key_clr,
  output logic              key_armed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_unc,
  output logic [1:0]        dbg_key_state
);

  typedef enum logic [1:0] {
    KEY_EMPTY   = 2'd0,
    KEY_LOADING = 2'd1,
    KEY_ARMED   = 2'd2
  } key_state_e;

  localparam int               CNT_W    = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);
  localparam logic [CHK_W-1:0] N_SYN    = CHK_W'(N);
  localparam logic [N-1:0]     ONE_N    = N'(1);

  // Codeword bits whose Hamming position has bit j set.
  function automatic logic [N-1:0] pos_mask(input int j);
    logic [N-1:0] m;
    m = '0;
    for (int p = 1; p <= N; p++)
      if (((p >> j) & 1) == 1) m = m | (ONE_N << (p - 1));
    return m;
  endfunction

  function automatic logic [N-1:0] odd_mask(input bit hi);
    logic [N-1:0] m;
    m = '0;
    for (int p = 1; p <= N; p++)
      if (((p % 2) == 1) && ((p > N / 2) == hi)) m = m | (ONE_N << (p - 1));
    return m;
  endfunction

  // Hamming position of data bit d (non-power-of-two positions, ascending).
  function automatic int data_pos(input int d);
    int k;
    int pos;
    k   = 0;
    pos = 1;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        if (k == d) pos = p;
        k++;
      end
    return pos;
  endfunction

  key_state_e         key_state_q;
  logic [CNT_W-1:0]   key_cnt_q;
  logic [KEY_W-1:0]   key_sr_q;
  logic [KEY_W-1:0]   key_sr_d;
  logic [KEY_W-1:0]   key_q;
  logic [DATA_W-1:0]  key_omask;
  logic [CHK_W-1:0]   key_smask;
  logic [3:0]         key_lut;

  assign key_sr_d      = {key_in, key_sr_q[KEY_W-1:1]};
  assign key_omask     = key_q[DATA_W-1:0];
  assign key_smask     = key_q[N-1:DATA_W];
  assign key_lut       = key_q[KEY_W-1:N];
  assign key_armed     = (key_state_q == KEY_ARMED);
  assign dbg_key_state = key_state_q;

  // The committed key only changes on the cycle the last bit shifts in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state_q <= KEY_EMPTY;
      key_cnt_q   <= '0;
      key_sr_q    <= '0;
      key_q       <= '0;
    end else if (key_clr) begin
      key_state_q <= KEY_EMPTY;
      key_cnt_q   <= '0;
    end else if (key_we) begin
      key_sr_q <= key_sr_d;
      case (key_state_q)
        KEY_LOADING: begin
          if (key_cnt_q == CNT_LAST) begin
            key_q       <= key_sr_d;
            key_state_q <= KEY_ARMED;
            key_cnt_q   <= '0;
          end else begin
            key_cnt_q <= key_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          key_state_q <= KEY_LOADING;
          key_cnt_q   <= CNT_W'(1);
        end
      endcase
    end
  end

  logic              s1_valid_q;
  logic [N-1:0]      s1_code_q;
  logic [CHK_W-1:0]  s1_syn_q;
  logic [DATA_W-1:0] s1_omask_q;
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;
  logic              s2_corr_q;
  logic              s2_unc_q;
  logic              s1_adv;
  logic              accept;

  // valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // a stalled stage holds its contents and outputs unchanged.
  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = key_armed && (!s1_valid_q || s1_adv);
  assign accept   = in_valid && in_ready;

  logic [CHK_W-1:0] syn_raw;
  logic             p_lo;
  logic             p_hi;

  assign p_lo       = ^(in_code & odd_mask(1'b0));
  assign p_hi       = ^(in_code & odd_mask(1'b1));
  assign syn_raw[0] = key_lut[{p_hi, p_lo}];

  for (genvar j = 1; j < CHK_W; j++) begin : g_syn
    assign syn_raw[j] = ^(in_code & pos_mask(j));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_omask_q <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_code_q  <= in_code;
      s1_syn_q   <= syn_raw ^ key_smask;
      s1_omask_q <= key_omask;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  logic              fix_corr;
  logic              fix_unc;
  logic [N-1:0]      code_fix;
  logic [DATA_W-1:0] data_x;

  assign fix_unc  = s1_syn_q > N_SYN;
  assign fix_corr = (s1_syn_q != '0) && !fix_unc;
  assign code_fix = fix_corr ? (s1_code_q ^ (ONE_N << (s1_syn_q - CHK_W'(1)))) : s1_code_q;

  for (genvar d = 0; d < DATA_W; d++) begin : g_data
    assign data_x[d] = |(code_fix & (ONE_N << (data_pos(d) - 1)));
  end

  // The output mask travels with the word so a reload cannot affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_corr_q  <= 1'b0;
      s2_unc_q   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= data_x ^ s1_omask_q;
        s2_corr_q <= fix_corr;
        s2_unc_q  <= fix_unc;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_corr  = s2_corr_q;
  assign out_unc   = s2_unc_q;

endmodule

// File: tb/tb_sec_lock_pipe.sv
// Bench for sec_lock_pipe: random and directed codewords against a positional Hamming model,
// results popped from an expected queue by an independent output monitor.
module tb_sec_lock_pipe;
  localparam int DATA_W = 32;
  localparam int CHK_W  = 6;
  localparam int N      = DATA_W + CHK_W;
  localparam int KEY_W  = N + 4;

  logic              clk;
  logic              rst_n;
  logic              key_we;
  logic              key_in;
  logic              key_clr;
  logic              key_armed;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_corr;
  logic              out_unc;
  logic [1:0]        dbg_key_state;

  sec_lock_pipe #(.DATA_W(DATA_W), .CHK_W(CHK_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_we(key_we), .key_in(key_in), .key_clr(key_clr), .key_armed(key_armed),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_corr(out_corr), .out_unc(out_unc), .dbg_key_state(dbg_key_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W+1:0] exp_q[$];
  logic [KEY_W-1:0]  model_key = '0;
  int bp_mode = 0;

  localparam logic [KEY_W-1:0] KEY_GOOD  = {4'b0110, {N{1'b0}}};
  localparam logic [KEY_W-1:0] KEY_WRONG = {4'b0000, {N{1'b0}}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DATA_W+1:0] model(input logic [N-1:0] code_in,
                                              input logic [KEY_W-1:0] key);
    logic [N-1:0]      code;
    logic [3:0]        lut;
    logic [DATA_W-1:0] data;
    int syn, plo, phi, k;
    bit corr, unc;
    code = code_in;
    syn = 0; plo = 0; phi = 0; k = 0; data = '0;
    for (int p = 1; p <= N; p++)
      if (code[p-1]) begin
        syn ^= p;
        if (p % 2 == 1) begin
          if (p <= N / 2) plo ^= 1;
          else phi ^= 1;
        end
      end
    lut  = key[KEY_W-1:N];
    syn  = (syn & ~1) | int'(lut[phi*2 + plo]);
    syn  = syn ^ int'(key[N-1:DATA_W]);
    corr = (syn >= 1) && (syn <= N);
    unc  = syn > N;
    if (corr) code[syn-1] = ~code[syn-1];
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        data[k] = code[p-1];
        k++;
      end
    data ^= key[DATA_W-1:0];
    return {data, corr, unc};
  endfunction

  function automatic logic [N-1:0] encode(input logic [DATA_W-1:0] d);
    logic [N-1:0] c;
    int k, syn;
    c = '0; k = 0; syn = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    for (int p = 1; p <= N; p++) if (c[p-1]) syn ^= p;
    for (int j = 0; j < CHK_W; j++) if (((syn >> j) & 1) == 1) c[(1 << j) - 1] = 1'b1;
    return c;
  endfunction

  function automatic logic [N-1:0] rand_code();
    logic [N-1:0] c;
    logic [63:0]  r64;
    int r;
    c = encode($urandom);
    r = $urandom_range(0, 3);
    if (r == 1 || r == 2) c[$urandom_range(0, N-1)] ^= 1'b1;
    else if (r == 3) begin
      r64 = {$urandom, $urandom};
      c   = r64[N-1:0];
    end
    return c;
  endfunction

  function automatic logic [KEY_W-1:0] rand_key();
    logic [63:0] r64;
    r64 = {$urandom, $urandom};
    return r64[KEY_W-1:0];
  endfunction

  // ---------------- output backpressure ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic              stall_prev;
    logic [DATA_W+1:0] prev;
    logic [DATA_W+1:0] got;
    logic [DATA_W+1:0] e;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        got = {out_data, out_corr, out_unc};
        if (stall_prev) check("stall_hold", {out_valid, got}, {1'b1, prev});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got 0x%0h with no result expected", got);
          end else begin
            e = exp_q.pop_front();
            check("result", got, e);
          end
        end
        stall_prev = out_valid && !out_ready;
        prev = got;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] code, input logic [DATA_W+1:0] exp);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = code;
    #1;
    while (!in_ready && wait_cnt < 200) begin
      @(negedge clk);
      #1;
      wait_cnt++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", wait_cnt);
    end else begin
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [N-1:0] code);
    send(code, model(code, model_key));
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load_key(input logic [KEY_W-1:0] key, input bit pipe_idle);
    for (int i = 0; i < KEY_W; i++) begin
      @(negedge clk);
      key_we = 1'b1;
      key_in = key[i];
      #1;
      if (i == KEY_W / 2) begin
        check("armed_mid_load", key_armed, 0);
        check("ready_mid_load", in_ready, 0);
      end
      if (i == KEY_W - 1) check("armed_before_last_bit", key_armed, 0);
    end
    @(negedge clk);
    key_we = 1'b0;
    #1;
    check("armed_after_load", key_armed, 1);
    if (pipe_idle) check("ready_on_arm", in_ready, 1);
    model_key = key;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    rst_n = 1'b0; key_we = 1'b0; key_in = 1'b0; key_clr = 1'b0;
    in_valid = 1'b0; in_code = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_flags", {out_corr, out_unc}, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_key_armed", key_armed, 0);
    check("rst_key_state", dbg_key_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    load_key(KEY_GOOD, 1'b1);

    // latency: presented in one cycle, visible after the second rising edge
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = '0;
    #1;
    check("lat_ready", in_ready, 1);
    exp_q.push_back({32'h0000_0000, 1'b0, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat_one_edge", out_valid, 0);
    @(negedge clk);
    #1;
    check("lat_two_edges", out_valid, 1);
    drain();

    send(38'h1 << 4, {32'h0000_0000, 1'b1, 1'b0});
    send((38'h1 << 31) | (38'h1 << 6), {32'h0000_0008, 1'b0, 1'b1});
    drain();

    bp_mode = 1;
    for (int i = 0; i < 30; i++) send_model(rand_code());
    drain();

    // stall the consumer while a burst of four arrives
    bp_mode = 2;
    @(posedge clk);
    #3;
    fork
      begin
        for (int i = 0; i < 4; i++) send_model(rand_code());
      end
      begin
        repeat (4) @(negedge clk);
        #2;
        check("bp_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        bp_mode = 0;
      end
    join
    drain();

    load_key(rand_key(), 1'b1);
    bp_mode = 1;
    for (int i = 0; i < 25; i++) send_model(rand_code());
    drain();

    // words in flight keep the key they entered with across a reload
    bp_mode = 2;
    @(posedge clk);
    #3;
    send_model(rand_code());
    send_model(encode($urandom) ^ (38'h1 << $urandom_range(0, N-1)));
    load_key(KEY_WRONG, 1'b0);
    bp_mode = 0;
    drain();

    send(38'h1 << 2, {32'h0000_0001, 1'b1, 1'b0});
    bp_mode = 1;
    for (int i = 0; i < 15; i++) send_model(rand_code());
    drain();

    // clear mid-load, full reload, then async reset mid-reload with results in flight
    bp_mode = 2;
    @(posedge clk);
    #3;
    send_model(rand_code());
    send_model(rand_code());
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key_we = 1'b1;
      key_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    key_we = 1'b1; key_clr = 1'b1; key_in = 1'b1;
    @(negedge clk);
    key_we = 1'b0; key_clr = 1'b0;
    #1;
    check("clr_state", dbg_key_state, 0);
    check("clr_armed", key_armed, 0);
    check("clr_ready", in_ready, 0);
    load_key(KEY_GOOD, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key_we = 1'b1;
      key_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    key_we = 1'b0;
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_state", dbg_key_state, 0);
    check("arst_ready", in_ready, 0);
    check("arst_armed", key_armed, 0);
    check("arst_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bp_mode = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("no_pulse_after_reset", seen, 0);

    load_key(KEY_GOOD, 1'b1);
    for (int i = 0; i < 10; i++) send_model(rand_code());
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
